// File: rtl/cv32e40x_obi_trans_tracker.sv
// OBI master-side transaction tracker: caps outstanding A-phases, returns each
// R-phase with the tag of its request, and flags spurious rvalid / unstable requests.
module cv32e40x_obi_trans_tracker #(
  parameter int MAX_OUTSTANDING = 2,
  parameter int TAG_W           = 4,
  parameter int ADDR_W          = 32
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 up_req_i,
  input  logic [ADDR_W-1:0]                    up_addr_i,
  input  logic [TAG_W-1:0]                     up_tag_i,
  output logic                                 up_gnt_o,
  output logic                                 obi_req_o,
  output logic [ADDR_W-1:0]                    obi_addr_o,
  input  logic                                 obi_gnt_i,
  input  logic                                 obi_rvalid_i,
  output logic                                 resp_valid_o,
  output logic [TAG_W-1:0]                     resp_tag_o,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
  output logic                                 empty_o,
  output logic                                 full_o,
  output logic [1:0]                           err_o
);

  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUTSTANDING - 1);
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUTSTANDING);

  logic [TAG_W-1:0]  r_tags [MAX_OUTSTANDING];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_pend;
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_err;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;
  logic w_spurious;
  logic w_unstable;
  logic w_wait;

  // Explicit wrap compare so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] f_next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == MAX_CNT);
  assign obi_req_o  = up_req_i & ~w_full;
  assign obi_addr_o = up_addr_i;
  assign up_gnt_o   = obi_req_o & obi_gnt_i;
  assign w_push     = up_gnt_o;
  assign w_pop      = obi_rvalid_i & ~w_empty;
  assign w_spurious = obi_rvalid_i & w_empty;
  assign w_wait     = obi_req_o & ~obi_gnt_i;
  assign w_unstable = r_pend & (~up_req_i | (up_addr_i != r_addr));

  assign resp_valid_o  = w_pop;
  assign resp_tag_o    = r_tags[r_rptr];
  assign outstanding_o = r_count;
  assign empty_o       = w_empty;
  assign full_o        = w_full;
  assign err_o         = r_err;

  // Tag storage is deliberately left unreset; only pointers/count define validity.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_tags[r_wptr] <= up_tag_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_pend  <= 1'b0;
      r_addr  <= '0;
      r_err   <= 2'b00;
    end else begin
      if (w_push) begin
        r_wptr <= f_next_ptr(r_wptr);
      end
      if (w_pop) begin
        r_rptr <= f_next_ptr(r_rptr);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CNT_W'(1);
      end
      r_pend <= w_wait;
      if (w_wait) begin
        r_addr <= up_addr_i;
      end
      r_err <= r_err | {w_unstable, w_spurious};
    end
  end

endmodule

// File: tb/tb_cv32e40x_obi_trans_tracker.sv
// Bench for the OBI transaction tracker: a depth-2 and a depth-3 instance share
// stimulus and are compared every cycle against a queue-based reference model.
module tb_cv32e40x_obi_trans_tracker;

  localparam int MAX_A = 2;
  localparam int MAX_B = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        up_req = 1'b0;
  logic [31:0] up_addr = '0;
  logic [3:0]  up_tag = '0;
  logic        obi_gnt = 1'b0;
  logic        obi_rvalid = 1'b0;

  logic        up_gnt_a, obi_req_a, resp_valid_a, empty_a, full_a;
  logic [31:0] obi_addr_a;
  logic [3:0]  resp_tag_a;
  logic [1:0]  outstanding_a, err_a;
  logic        up_gnt_b, obi_req_b, resp_valid_b, empty_b, full_b;
  logic [31:0] obi_addr_b;
  logic [3:0]  resp_tag_b;
  logic [1:0]  outstanding_b, err_b;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  cv32e40x_obi_trans_tracker #(.MAX_OUTSTANDING(MAX_A), .TAG_W(4), .ADDR_W(32)) u_dut_a (
    .clk(clk), .rst(rst), .up_req_i(up_req), .up_addr_i(up_addr), .up_tag_i(up_tag),
    .up_gnt_o(up_gnt_a), .obi_req_o(obi_req_a), .obi_addr_o(obi_addr_a),
    .obi_gnt_i(obi_gnt), .obi_rvalid_i(obi_rvalid), .resp_valid_o(resp_valid_a),
    .resp_tag_o(resp_tag_a), .outstanding_o(outstanding_a), .empty_o(empty_a),
    .full_o(full_a), .err_o(err_a)
  );

  cv32e40x_obi_trans_tracker #(.MAX_OUTSTANDING(MAX_B), .TAG_W(4), .ADDR_W(32)) u_dut_b (
    .clk(clk), .rst(rst), .up_req_i(up_req), .up_addr_i(up_addr), .up_tag_i(up_tag),
    .up_gnt_o(up_gnt_b), .obi_req_o(obi_req_b), .obi_addr_o(obi_addr_b),
    .obi_gnt_i(obi_gnt), .obi_rvalid_i(obi_rvalid), .resp_valid_o(resp_valid_b),
    .resp_tag_o(resp_tag_b), .outstanding_o(outstanding_b), .empty_o(empty_b),
    .full_o(full_b), .err_o(err_b)
  );

  // Reference model: one queue of in-flight tags per instance plus sticky errors.
  logic [3:0]  q0[$];
  logic [3:0]  q1[$];
  logic [1:0]  m_err[2]  = '{2'b00, 2'b00};
  logic        m_pend[2] = '{1'b0, 1'b0};
  logic [31:0] m_held[2] = '{32'h0, 32'h0};

  function automatic int msize(input int k);
    return (k == 0) ? q0.size() : q1.size();
  endfunction

  function automatic logic [44:0] exp_vec(input int k);
    int sz, mx;
    logic req, rv;
    logic [3:0] head;
    sz = msize(k);
    mx = (k == 0) ? MAX_A : MAX_B;
    head = 4'h0;
    if (sz > 0) head = (k == 0) ? q0[0] : q1[0];
    req = up_req && (sz < mx);
    rv  = obi_rvalid && (sz > 0);
    return {up_addr, req, req && obi_gnt, rv, rv ? head : 4'h0, 2'(sz),
            sz == 0, sz == mx, m_err[k]};
  endfunction

  function automatic logic [44:0] obs_vec(input int k);
    if (k == 0)
      return {obi_addr_a, obi_req_a, up_gnt_a, resp_valid_a, resp_valid_a ? resp_tag_a : 4'h0,
              outstanding_a, empty_a, full_a, err_a};
    return {obi_addr_b, obi_req_b, up_gnt_b, resp_valid_b, resp_valid_b ? resp_tag_b : 4'h0,
            outstanding_b, empty_b, full_b, err_b};
  endfunction

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      int sz, mx;
      logic req, push, pop;
      sz = msize(k);
      mx = (k == 0) ? MAX_A : MAX_B;
      if (rst) begin
        if (k == 0) q0.delete(); else q1.delete();
        m_err[k]  = 2'b00;
        m_pend[k] = 1'b0;
      end else begin
        req  = up_req && (sz < mx);
        push = req && obi_gnt;
        pop  = obi_rvalid && (sz > 0);
        if (obi_rvalid && sz == 0) m_err[k][0] = 1'b1;
        if (m_pend[k] && (!up_req || up_addr != m_held[k])) m_err[k][1] = 1'b1;
        if (pop) begin
          if (k == 0) void'(q0.pop_front()); else void'(q1.pop_front());
        end
        if (push) begin
          if (k == 0) q0.push_back(up_tag); else q1.push_back(up_tag);
        end
        m_pend[k] = req && !obi_gnt;
        if (m_pend[k]) m_held[k] = up_addr;
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic req, input logic [31:0] addr, input logic [3:0] tag,
                       input logic gnt, input logic rv);
    up_req = req; up_addr = addr; up_tag = tag; obi_gnt = gnt; obi_rvalid = rv;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    drive(1, 32'h40, 4'h3, 1, 0);
    @(negedge clk);
    n_run++;
    if ({obi_req_a, up_gnt_a, resp_valid_a, outstanding_a, empty_a, full_a, err_a} !==
        {1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 2'b00}) begin
      n_fail++;
      $display("FAIL reset_idle got req=%b gnt=%b rv=%b cnt=%0d e=%b f=%b err=%b need 1 1 0 0 1 0 00",
               obi_req_a, up_gnt_a, resp_valid_a, outstanding_a, empty_a, full_a, err_a);
    end
    tick();
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    n_run++;
    if ({outstanding_a, empty_a, err_a} !== {2'd1, 1'b0, 2'b00}) begin
      n_fail++;
      $display("FAIL reset_push got cnt=%0d empty=%b err=%b need 1 0 00", outstanding_a, empty_a, err_a);
    end
    for (int k = 0; k < 2; k++) begin
      n_run++;
      if (obs_vec(k) !== exp_vec(k)) begin
        n_fail++;
        $display("FAIL reset_model dut%0d got=%h exp=%h", k, obs_vec(k), exp_vec(k));
      end
    end
    tick();
  endtask

  task automatic test_fill_block();
    logic [3:0] tags[5] = '{4'hA, 4'hB, 4'hC, 4'h0, 4'h0};
    do_reset();
    for (int c = 0; c < 6; c++) begin
      if (c < 3) drive(1, 32'h10 + 32'(4 * c), tags[c], 1, 0);
      else drive(0, 0, 0, 0, (c < 5));
      @(negedge clk);
      if (c == 2) begin
        n_run++;
        if ({full_a, outstanding_a, obi_req_a, up_gnt_a} !== {1'b1, 2'd2, 1'b0, 1'b0}) begin
          n_fail++;
          $display("FAIL fill_block got full=%b cnt=%0d req=%b gnt=%b need 1 2 0 0",
                   full_a, outstanding_a, obi_req_a, up_gnt_a);
        end
      end
      if (c == 3 || c == 4) begin
        n_run++;
        if ({resp_valid_a, resp_tag_a} !== {1'b1, tags[c-3]}) begin
          n_fail++;
          $display("FAIL fill_resp got rv=%b tag=%h need 1 %h", resp_valid_a, resp_tag_a, tags[c-3]);
        end
      end
      if (c == 5) begin
        n_run++;
        if ({empty_a, err_a} !== {1'b1, 2'b00}) begin
          n_fail++;
          $display("FAIL fill_drain got empty=%b err=%b need 1 00", empty_a, err_a);
        end
      end
      for (int k = 0; k < 2; k++) begin
        n_run++;
        if (obs_vec(k) !== exp_vec(k)) begin
          n_fail++;
          $display("FAIL fill_model dut%0d cyc%0d got=%h exp=%h", k, c, obs_vec(k), exp_vec(k));
        end
      end
      tick();
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    for (int c = 0; c < 5; c++) begin
      case (c)
        0: drive(1, 32'h20, 4'h5, 1, 0);
        1: drive(1, 32'h24, 4'h6, 1, 1);
        3: drive(0, 0, 0, 0, 1);
        default: drive(0, 0, 0, 0, 0);
      endcase
      @(negedge clk);
      if (c == 1) begin
        n_run++;
        if ({resp_valid_a, resp_tag_a, up_gnt_a} !== {1'b1, 4'h5, 1'b1}) begin
          n_fail++;
          $display("FAIL simul_pop got rv=%b tag=%h gnt=%b need 1 5 1", resp_valid_a, resp_tag_a, up_gnt_a);
        end
      end
      if (c == 2) begin
        n_run++;
        if (outstanding_a !== 2'd1) begin
          n_fail++;
          $display("FAIL simul_count got %0d need 1", outstanding_a);
        end
      end
      if (c == 3) begin
        n_run++;
        if ({resp_valid_a, resp_tag_a} !== {1'b1, 4'h6}) begin
          n_fail++;
          $display("FAIL simul_next got rv=%b tag=%h need 1 6", resp_valid_a, resp_tag_a);
        end
      end
      for (int k = 0; k < 2; k++) begin
        n_run++;
        if (obs_vec(k) !== exp_vec(k)) begin
          n_fail++;
          $display("FAIL simul_model dut%0d cyc%0d got=%h exp=%h", k, c, obs_vec(k), exp_vec(k));
        end
      end
      tick();
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 9; i++) begin
      drive(i < 7, 32'h1000 + 32'(4 * i), 4'(i), i < 7, (i > 0) && (i < 8));
      @(negedge clk);
      if (i > 0 && i < 8) begin
        n_run++;
        if ({resp_valid_b, resp_tag_b} !== {1'b1, 4'(i - 1)}) begin
          n_fail++;
          $display("FAIL wrap_resp got rv=%b tag=%h need 1 %h", resp_valid_b, resp_tag_b, 4'(i - 1));
        end
      end
      if (i == 8) begin
        n_run++;
        if ({err_b, err_a, empty_b} !== {2'b00, 2'b00, 1'b1}) begin
          n_fail++;
          $display("FAIL wrap_end got err_b=%b err_a=%b empty_b=%b need 00 00 1", err_b, err_a, empty_b);
        end
      end
      for (int k = 0; k < 2; k++) begin
        n_run++;
        if (obs_vec(k) !== exp_vec(k)) begin
          n_fail++;
          $display("FAIL wrap_model dut%0d cyc%0d got=%h exp=%h", k, i, obs_vec(k), exp_vec(k));
        end
      end
      tick();
    end
  endtask

  task automatic test_spurious();
    do_reset();
    drive(0, 0, 0, 0, 1);
    @(negedge clk);
    n_run++;
    if ({resp_valid_a, resp_valid_b} !== 2'b00) begin
      n_fail++;
      $display("FAIL spur_rvalid got rv_a=%b rv_b=%b need 0 0", resp_valid_a, resp_valid_b);
    end
    tick();
    drive(0, 0, 0, 0, 0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_run++;
      if ({err_a, err_b} !== {2'b01, 2'b01}) begin
        n_fail++;
        $display("FAIL spur_sticky cyc%0d got err_a=%b err_b=%b need 01 01", c, err_a, err_b);
      end
      tick();
    end
    do_reset();
    @(negedge clk);
    n_run++;
    if (err_a !== 2'b00) begin
      n_fail++;
      $display("FAIL spur_clear got %b need 00", err_a);
    end
    // Reset with a transaction in flight: its late rvalid must be flagged.
    drive(1, 32'h30, 4'h7, 1, 0);
    tick();
    do_reset();
    drive(0, 0, 0, 0, 1);
    @(negedge clk);
    n_run++;
    if ({resp_valid_a, empty_a} !== 2'b01) begin
      n_fail++;
      $display("FAIL spur_midrst got rv=%b empty=%b need 0 1", resp_valid_a, empty_a);
    end
    tick();
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    n_run++;
    if (err_a !== 2'b01) begin
      n_fail++;
      $display("FAIL spur_midrst_err got %b need 01", err_a);
    end
    tick();
  endtask

  task automatic test_retraction();
    do_reset();
    drive(1, 32'h100, 4'h1, 0, 0);
    tick();
    drive(1, 32'h104, 4'h1, 0, 0);
    @(negedge clk);
    n_run++;
    if (err_a !== 2'b00) begin
      n_fail++;
      $display("FAIL retr_early got %b need 00", err_a);
    end
    tick();
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    n_run++;
    if (err_a !== 2'b10) begin
      n_fail++;
      $display("FAIL retr_addr got %b need 10", err_a);
    end
    tick();
    // Stable hold until grant, then drop: legal.
    do_reset();
    for (int c = 0; c < 4; c++) begin
      drive(c < 3, 32'h200, 4'h2, c == 2, 0);
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        n_run++;
        if (obs_vec(k) !== exp_vec(k)) begin
          n_fail++;
          $display("FAIL retr_model dut%0d cyc%0d got=%h exp=%h", k, c, obs_vec(k), exp_vec(k));
        end
      end
      tick();
    end
    n_run++;
    if (err_a !== 2'b00) begin
      n_fail++;
      $display("FAIL retr_stable got %b need 00", err_a);
    end
    drive(1, 32'h300, 4'h3, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    tick();
    @(negedge clk);
    n_run++;
    if ({err_a, err_b} !== {2'b10, 2'b10}) begin
      n_fail++;
      $display("FAIL retr_drop got err_a=%b err_b=%b need 10 10", err_a, err_b);
    end
    tick();
  endtask

  task automatic test_random();
    logic [31:0] addr;
    do_reset();
    addr = $urandom;
    for (int c = 0; c < 400; c++) begin
      if (!(up_req && $urandom_range(0, 7) != 0)) addr = {$urandom_range(0, 255), 2'b00};
      rst = ($urandom_range(0, 52) == 0);
      drive($urandom_range(0, 3) != 0, addr, 4'($urandom), 1'($urandom_range(0, 1)),
            $urandom_range(0, 2) == 0);
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        n_run++;
        if (obs_vec(k) !== exp_vec(k)) begin
          n_fail++;
          $display("FAIL rand_model dut%0d cyc%0d got=%h exp=%h", k, c, obs_vec(k), exp_vec(k));
        end
      end
      tick();
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fill_block();
    test_simultaneous();
    test_wrap();
    test_spurious();
    test_retraction();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
